lcd_init_module: RTL and testbench

Power-on initialisation sequencer for the SPI 12864 LCD (ST7565-class controller). It is started by the LCD control stage through the `Init_Start_Sig` / `Init_Done_Sig` handshake. It pulses the panel hardware reset, then issues a fixed 10-byte command sequence through the SPI write stage, one byte per start/done handshake. When the sequence is complete it reports `Init_Done_Sig` so the control stage can hand over to the draw stage.

---
 rtl/lcd_init_module.sv | 146 ++++++++++++++
 tb/tb_lcd_init_module.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_module.sv
// Power-on initialisation sequencer for an ST7565-class SPI 12864 LCD.
// Pulses the panel hardware reset, waits for the controller to settle, then
// pushes a fixed 10-byte command list through the SPI write stage, one byte
// per start/done handshake, and finally reports a one-cycle done pulse.
module lcd_init_module #(
    parameter int RST_LOW_CYCLES  = 500,
    parameter int RST_WAIT_CYCLES = 50000,
    parameter int CMD_GAP_CYCLES  = 10
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Init_Start_Sig,
    output logic       Init_Done_Sig,
    output logic       LCD_RSTn,
    output logic       SPI_Start_Sig,
    output logic [8:0] SPI_Data,
    input  logic       SPI_Done_Sig
);

    // Terminal counts: the counter starts at 0 on state entry, so a phase of
    // N cycles ends when the counter reaches N-1.
    localparam logic [15:0] RST_LOW_LAST  = 16'(RST_LOW_CYCLES - 1);
    localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT_CYCLES - 1);
    localparam logic [15:0] CMD_GAP_LAST  = 16'(CMD_GAP_CYCLES - 1);
    localparam logic [3:0]  NUM_CMDS      = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_SEND,
        ST_GAP,
        ST_DONE,
        ST_END
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  idx;

    // Controller bring-up command list: reset, bias, ADC/COM direction,
    // power control, regulator ratio, contrast, start line, display on.
    function automatic logic [7:0] cmd_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'hE2;
            4'd1:    b = 8'hA2;
            4'd2:    b = 8'hA0;
            4'd3:    b = 8'hC8;
            4'd4:    b = 8'h2F;
            4'd5:    b = 8'h26;
            4'd6:    b = 8'h81;
            4'd7:    b = 8'h10;
            4'd8:    b = 8'h40;
            4'd9:    b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Sequencer FSM; every output is a register updated on the transition
    // that enters the state where it must change.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= ST_IDLE;
            cnt           <= 16'd0;
            idx           <= 4'd0;
            Init_Done_Sig <= 1'b0;
            LCD_RSTn      <= 1'b1;
            SPI_Start_Sig <= 1'b0;
            SPI_Data      <= 9'h000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Init_Start_Sig) begin
                        state    <= ST_RST_LOW;
                        LCD_RSTn <= 1'b0;
                        cnt      <= 16'd0;
                        idx      <= 4'd0;
                    end
                end
                ST_RST_LOW: begin
                    if (cnt == RST_LOW_LAST) begin
                        state    <= ST_RST_WAIT;
                        LCD_RSTn <= 1'b1;
                        cnt      <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt == RST_WAIT_LAST) begin
                        state         <= ST_SEND;
                        SPI_Start_Sig <= 1'b1;
                        SPI_Data      <= {1'b0, cmd_byte(idx)};
                        cnt           <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    // Start and data stay frozen until the SPI stage finishes.
                    if (SPI_Done_Sig) begin
                        state         <= ST_GAP;
                        SPI_Start_Sig <= 1'b0;
                        idx           <= idx + 4'd1;
                        cnt           <= 16'd0;
                    end
                end
                ST_GAP: begin
                    if (cnt == CMD_GAP_LAST) begin
                        cnt <= 16'd0;
                        if (idx < NUM_CMDS) begin
                            state         <= ST_SEND;
                            SPI_Start_Sig <= 1'b1;
                            SPI_Data      <= {1'b0, cmd_byte(idx)};
                        end else begin
                            state         <= ST_DONE;
                            Init_Done_Sig <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    Init_Done_Sig <= 1'b0;
                    state         <= ST_END;
                    cnt           <= 16'd0;
                end
                ST_END: begin
                    // The control stage still holds start for a cycle after
                    // the done pulse; only a low level re-arms the block.
                    if (!Init_Start_Sig) begin
                        state <= ST_IDLE;
                        cnt   <= 16'd0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_init_module.sv
// Directed bench for lcd_init_module: byte-order/timing table plus hand-written
// sequences for reset, restart suppression, mid-byte reset and early start drop.
module tb_lcd_init_module;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       Init_Start_Sig;
    logic       Init_Done_Sig;
    logic       LCD_RSTn;
    logic       SPI_Start_Sig;
    logic [8:0] SPI_Data;
    logic       resp_done;
    logic       spur_done;
    logic       spi_done;

    assign spi_done = resp_done | spur_done;

    lcd_init_module #(
        .RST_LOW_CYCLES (4),
        .RST_WAIT_CYCLES(8),
        .CMD_GAP_CYCLES (2)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .Init_Start_Sig(Init_Start_Sig),
        .Init_Done_Sig (Init_Done_Sig),
        .LCD_RSTn      (LCD_RSTn),
        .SPI_Start_Sig (SPI_Start_Sig),
        .SPI_Data      (SPI_Data),
        .SPI_Done_Sig  (spi_done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic       spur;   // inject a stray SPI done in the gap after this byte
        logic [8:0] data;   // expected SPI_Data
        int         rel;    // expected start-rise edge relative to e0
    } vec_t;
    vec_t tbl[10];

    // Monitor state
    int         rst_low_cnt, rst_pulses, gap_err, unstable, done_cnt, done_cyc, done_long, low_run;
    int         rise_cyc[$];
    logic [8:0] rise_dat[$];
    logic       prev_lcd = 1'b1, prev_start = 1'b0, prev_done = 1'b0;
    logic [8:0] prev_data = 9'h000;

    // SPI responder: done pulse sampled 5 edges after start rises.
    int resp_cnt = 0;
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge CLK);
            resp_done = 1'b0;
            if (SPI_Start_Sig) begin
                if (resp_cnt == 4) begin
                    resp_done = 1'b1;
                    resp_cnt  = 0;
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!LCD_RSTn) begin
                rst_low_cnt++;
                if (prev_lcd) rst_pulses++;
            end
            if (SPI_Start_Sig && !prev_start) begin
                if (rise_cyc.size() > 0 && low_run < 2) gap_err++;
                rise_cyc.push_back(cyc);
                rise_dat.push_back(SPI_Data);
            end
            if (SPI_Start_Sig && prev_start && SPI_Data != prev_data) unstable++;
            low_run = SPI_Start_Sig ? 0 : low_run + 1;
            if (Init_Done_Sig) begin
                done_cnt++;
                done_cyc = cyc;
                if (prev_done) done_long++;
            end
            prev_lcd   = LCD_RSTn;
            prev_start = SPI_Start_Sig;
            prev_done  = Init_Done_Sig;
            prev_data  = SPI_Data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        rst_low_cnt = 0; rst_pulses = 0; gap_err = 0; unstable = 0;
        done_cnt = 0; done_cyc = -1; done_long = 0; low_run = 0;
        rise_cyc.delete();
        rise_dat.delete();
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Follows one full sequence whose start was sampled at edge e0.
    task automatic run_seq(input int e0, input bit spur_wait, input bit drop_early, input bit drop_after);
        int n;
        wait_cyc(e0 + 5);
        if (spur_wait) spur_done = 1'b1;   // lands in RST_WAIT
        if (drop_early) Init_Start_Sig = 1'b0;
        tick();
        spur_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            while (rise_cyc.size() <= k && n < 100) begin
                tick();
                n++;
            end
            if (rise_cyc.size() <= k) begin
                chk($sformatf("byte%0d_timeout", k), 0, 1);
                return;
            end
            chk($sformatf("byte%0d_rise", k), rise_cyc[k] - e0, tbl[k].rel);
            chk($sformatf("byte%0d_data", k), int'(rise_dat[k]), int'(tbl[k].data));
            if (tbl[k].spur) begin
                wait_cyc(rise_cyc[k] + 5);   // SPI done sampled here; gap follows
                spur_done = 1'b1;
                tick();
                spur_done = 1'b0;
            end
        end
        n = 0;
        while (done_cnt == 0 && n < 60) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt, 1);
        chk("done_time", done_cyc - e0, 82);
        if (drop_after) Init_Start_Sig = 1'b0;
        repeat (5) tick();
        chk("done_width", done_long, 0);
        chk("data_stable", unstable, 0);
        chk("gap_min", gap_err, 0);
        chk("rst_low_cycles", rst_low_cnt, 4);
        chk("rst_pulses", rst_pulses, 1);
    endtask

    initial begin
        logic [7:0] cmds [10];
        int e0;
        int n;
        cmds = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h2F, 8'h26, 8'h81, 8'h10, 8'h40, 8'hAF};
        for (int k = 0; k < 10; k++) begin
            tbl[k].data = {1'b0, cmds[k]};
            tbl[k].rel  = 12 + 7 * k;
            tbl[k].spur = (k == 1 || k == 4 || k == 9);
        end

        RSTn = 1'b0;
        Init_Start_Sig = 1'b1;
        spur_done = 1'b0;
        clear_mon();
        repeat (3) tick();

        // Reset state with start requested
        chk("rst_lcd_rstn", LCD_RSTn, 1);
        chk("rst_spi_start", SPI_Start_Sig, 0);
        chk("rst_init_done", Init_Done_Sig, 0);
        chk("rst_spi_data", SPI_Data, 0);

        // Nominal run, start held high forever afterwards
        clear_mon();
        RSTn = 1'b1;
        e0 = cyc + 1;
        run_seq(e0, 1'b1, 1'b0, 1'b0);
        repeat (100) tick();
        chk("hold_done_once", done_cnt, 1);
        chk("hold_no_restart", rst_pulses, 1);

        // Control-stage emulation: start dropped one cycle after done
        Init_Start_Sig = 1'b0;
        repeat (2) tick();
        clear_mon();
        Init_Start_Sig = 1'b1;
        e0 = cyc + 1;
        run_seq(e0, 1'b0, 1'b0, 1'b1);
        repeat (30) tick();
        chk("ctl_no_restart", rst_pulses, 1);
        chk("ctl_done_once", done_cnt, 1);
        clear_mon();
        Init_Start_Sig = 1'b1;
        tick();
        chk("ctl_back_in_idle", LCD_RSTn, 0);

        // Mid-sequence asynchronous reset during byte 5
        n = 0;
        while (!(SPI_Start_Sig && SPI_Data == 9'h026) && n < 300) begin
            tick();
            n++;
        end
        chk("mid_reach_byte5", SPI_Data, 9'h026);
        tick();
        RSTn = 1'b0;
        #1;
        chk("mid_lcd_rstn", LCD_RSTn, 1);
        chk("mid_spi_start", SPI_Start_Sig, 0);
        chk("mid_init_done", Init_Done_Sig, 0);
        chk("mid_spi_data", SPI_Data, 0);
        repeat (2) tick();
        clear_mon();
        RSTn = 1'b1;
        e0 = cyc + 1;
        run_seq(e0, 1'b0, 1'b0, 1'b1);
        repeat (10) tick();

        // Early start drop during RST_WAIT
        clear_mon();
        Init_Start_Sig = 1'b1;
        e0 = cyc + 1;
        run_seq(e0, 1'b1, 1'b1, 1'b0);
        repeat (20) tick();
        chk("early_no_restart", rst_pulses, 1);
        clear_mon();
        Init_Start_Sig = 1'b1;
        tick();
        chk("early_back_in_idle", LCD_RSTn, 0);
        Init_Start_Sig = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
